// File: rtl/spi_master_shifter.sv
// -----------------------------------------------------------------------------
// spi_master_shifter
//
// Purpose:
//   SPI master (mode 0) that sends one 16-bit frame per start request. The
//   frame is a command/address byte followed by a payload byte (write) or by
//   a dummy 8'h00 byte (read). In read mode the last eight bits clocked in
//   from the slave are presented on rx_data together with the done pulse.
//
// Ports:
//   m_clk     in   system clock, all state changes on the rising edge
//   n_reset   in   asynchronous active-low reset
//   start     in   one-cycle transaction request (ignored while busy/done)
//   rd_mode   in   1 = read frame, 0 = write frame
//   add_byte  in   [0:7] command/address byte, bit 0 goes out first
//   wr_data   in   [7:0] write payload, bit 7 goes out first
//   spi_miso  in   serial data from the slave
//   spi_sclk  out  SPI clock, idles low
//   spi_cs_n  out  active-low slave select
//   spi_mosi  out  serial data to the slave
//   rx_data   out  byte received in read mode
//   busy      out  high while a frame is on the wire
//   done      out  one-cycle completion pulse
//
// Parameter:
//   CLK_DIV   SCLK half-period in m_clk cycles (1..255)
//
// Build option:
//   SPI_MISO_CAPTURE_EN  when defined, MISO is sampled on every rising SCLK
//                        and rx_data is updated at the end of read frames.
//                        When undefined, MISO is ignored and rx_data is 8'h00.
// -----------------------------------------------------------------------------
module spi_master_shifter #(
  parameter int CLK_DIV = 4
) (
  input  logic       m_clk,
  input  logic       n_reset,
  input  logic       start,
  input  logic       rd_mode,
  input  logic [0:7] add_byte,
  input  logic [7:0] wr_data,
  input  logic       spi_miso,
  output logic       spi_sclk,
  output logic       spi_cs_n,
  output logic       spi_mosi,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_e;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_e      state_q, state_d;
  logic        pend_q, pend_d;      // frame latched, slave select drops next edge
  logic [15:0] frame_q, frame_d;    // bit 15 is the bit currently on MOSI
  logic [7:0]  div_cnt_q, div_cnt_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d; // falling SCLK edges seen so far
  logic        sclk_q, sclk_d;
  logic        cs_n_q, cs_n_d;
  logic        mosi_q, mosi_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        tick;                // half-period boundary
  logic        sample_en;           // this edge raises SCLK
  logic        frame_end;           // this edge closes the frame

  assign tick = (div_cnt_q == DIV_LAST);

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    frame_d   = frame_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sample_en = 1'b0;
    frame_end = 1'b0;

    case (state_q)
      IDLE: begin
        if (pend_q) begin
          state_d   = SETUP;
          pend_d    = 1'b0;
          cs_n_d    = 1'b0;
          busy_d    = 1'b1;
          mosi_d    = frame_q[15];
          div_cnt_d = 8'd0;
          bit_cnt_d = 5'd0;
        end else if (start && !done_q) begin
          // add_byte is declared [0:7], so bit 0 lands in frame bit 15
          pend_d  = 1'b1;
          frame_d = {add_byte, (rd_mode ? 8'h00 : wr_data)};
        end
      end

      SETUP: begin
        if (tick) begin
          div_cnt_d = 8'd0;
          sclk_d    = 1'b1;
          sample_en = 1'b1;
          state_d   = SHIFT;
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end

      SHIFT: begin
        if (tick) begin
          div_cnt_d = 8'd0;
          if (sclk_q) begin
            sclk_d    = 1'b0;
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd15) begin
              // last falling edge: MOSI keeps the final bit through HOLD
              state_d = HOLD;
            end else begin
              frame_d = {frame_q[14:0], 1'b0};
              mosi_d  = frame_q[14];
            end
          end else begin
            sclk_d    = 1'b1;
            sample_en = 1'b1;
          end
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end

      HOLD: begin
        if (tick) begin
          div_cnt_d = 8'd0;
          bit_cnt_d = 5'd0;
          cs_n_d    = 1'b1;
          busy_d    = 1'b0;
          mosi_d    = 1'b0;
          done_d    = 1'b1;
          frame_end = 1'b1;
          state_d   = IDLE;
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge m_clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= IDLE;
      pend_q    <= 1'b0;
      frame_q   <= 16'h0000;
      div_cnt_q <= 8'd0;
      bit_cnt_q <= 5'd0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      frame_q   <= frame_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

`ifdef SPI_MISO_CAPTURE_EN
  logic       rd_q, rd_d;
  logic [7:0] rx_sh_q, rx_sh_d;     // only the last eight samples are kept
  logic [7:0] rx_q, rx_d;

  always_comb begin
    rd_d    = rd_q;
    rx_sh_d = rx_sh_q;
    rx_d    = rx_q;
    if (state_q == IDLE && !pend_q && start && !done_q) begin
      rd_d = rd_mode;
    end
    if (sample_en) begin
      rx_sh_d = {rx_sh_q[6:0], spi_miso};
    end
    if (frame_end && rd_q) begin
      rx_d = rx_sh_q;
    end
  end

  always_ff @(posedge m_clk or negedge n_reset) begin
    if (!n_reset) begin
      rd_q    <= 1'b0;
      rx_sh_q <= 8'h00;
      rx_q    <= 8'h00;
    end else begin
      rd_q    <= rd_d;
      rx_sh_q <= rx_sh_d;
      rx_q    <= rx_d;
    end
  end

  assign rx_data = rx_q;
`else
  logic capture_unused;
  assign capture_unused = ^{spi_miso, rd_mode, sample_en, frame_end};
  assign rx_data        = 8'h00;
`endif

  assign spi_sclk = sclk_q;
  assign spi_cs_n = cs_n_q;
  assign spi_mosi = mosi_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_spi_master_shifter.sv
// -----------------------------------------------------------------------------
// tb_spi_master_shifter
//
// Two DUT instances: index 0 with CLK_DIV=4, index 1 with CLK_DIV=1. The
// stimulus process pushes one expected frame record per issued start; a
// monitor per instance accumulates what it sees on the SPI pins and pops
// and compares a record on every done pulse. A simple slave per instance
// shifts out 16'h5AA5 MSB first, so read frames should return 8'hA5 when
// MISO capture is built in (8'h00 otherwise).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_master_shifter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]      rst_n, start, rd_mode;
  logic [1:0][7:0] add_b, wr;
  logic [1:0]      sclk, cs_n, mosi, busy, done;
  logic [1:0][7:0] rx;

  typedef struct {
    logic [15:0] mosi;
    logic [7:0]  rx;
    int          k;
  } exp_t;

  exp_t            exp_q [2][$];
  logic [1:0][7:0] last_rx;
  int              n_tests = 0;
  int              n_fail  = 0;

`ifdef SPI_MISO_CAPTURE_EN
  localparam logic [7:0] RD_RX = 8'hA5;
`else
  localparam logic [7:0] RD_RX = 8'h00;
`endif

  task automatic chk(input string name, input int inst,
                     input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst=%0d got=%0h expected=%0h cyc=%0d",
               name, inst, act, exp, cyc);
    end
  endtask

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      localparam int D = (gi == 0) ? 4 : 1;

      logic        miso_l = 1'b0;
      logic [15:0] slave_word = 16'h5AA5;
      int          scnt = 0;
      logic        sprev = 1'b0;

      spi_master_shifter #(.CLK_DIV(D)) u_dut (
        .m_clk    (clk),
        .n_reset  (rst_n[gi]),
        .start    (start[gi]),
        .rd_mode  (rd_mode[gi]),
        .add_byte (add_b[gi]),
        .wr_data  (wr[gi]),
        .spi_miso (miso_l),
        .spi_sclk (sclk[gi]),
        .spi_cs_n (cs_n[gi]),
        .spi_mosi (mosi[gi]),
        .rx_data  (rx[gi]),
        .busy     (busy[gi]),
        .done     (done[gi])
      );

      // Slave: next bit presented after each rising SCLK, changes on negedge
      always @(negedge clk) begin
        if (cs_n[gi]) scnt = 0;
        else if (sclk[gi] && !sprev && scnt < 15) scnt++;
        sprev  = sclk[gi];
        miso_l = slave_word[15 - scnt];
      end

      // Monitor
      logic [15:0] mbits = 16'h0;
      int          rises = 0;
      int          low_cnt = 0;
      int          cs_first = 0;
      logic        busy_bad = 1'b0;
      logic        sclk_prev = 1'b0;
      exp_t        e;

      always @(negedge clk) begin
        if (done[gi] === 1'b1) begin
          if (exp_q[gi].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done inst=%0d got=1 expected=0 cyc=%0d", gi, cyc);
          end else begin
            e = exp_q[gi].pop_front();
            chk("done_cycle",   gi, cyc,      e.k + 1 + 33 * D);
            chk("cs_low_cycle", gi, cs_first, e.k + 1);
            chk("cs_low_len",   gi, low_cnt,  33 * D);
            chk("mosi_frame",   gi, mbits,    e.mosi);
            chk("sclk_rises",   gi, rises,    16);
            chk("rx_data",      gi, rx[gi],   e.rx);
            chk("busy_frame",   gi, busy_bad, 0);
            chk("busy_done",    gi, busy[gi], 0);
            chk("sclk_done",    gi, sclk[gi], 0);
            chk("mosi_done",    gi, mosi[gi], 0);
            $display("[TB] inst=%0d frame done cyc=%0d mosi=%h rx=%h",
                     gi, cyc, mbits, rx[gi]);
          end
        end
        if (cs_n[gi] === 1'b0) begin
          if (low_cnt == 0) cs_first = cyc;
          low_cnt++;
          if (busy[gi] !== 1'b1) busy_bad = 1'b1;
          if (sclk[gi] && !sclk_prev) begin
            mbits = {mbits[14:0], mosi[gi]};
            rises++;
          end
        end else begin
          low_cnt  = 0;
          rises    = 0;
          mbits    = 16'h0;
          busy_bad = 1'b0;
        end
        sclk_prev = sclk[gi];
      end
    end
  endgenerate

  // Drive a start on the current cycle; kofs is the distance to the accepting
  // edge, hold the number of cycles start stays high.
  task automatic issue(input int inst, input logic rd, input logic [7:0] add,
                       input logic [7:0] wd, input logic [15:0] exp_mosi,
                       input int kofs, input int hold, output int k);
    exp_t e;
    start[inst]   = 1'b1;
    rd_mode[inst] = rd;
    add_b[inst]   = add;
    wr[inst]      = wd;
    k      = cyc + kofs;
    e.mosi = exp_mosi;
    e.rx   = rd ? RD_RX : last_rx[inst];
    e.k    = k;
    last_rx[inst] = e.rx;
    exp_q[inst].push_back(e);
    repeat (hold) @(negedge clk);
    // scramble inputs so a frame that re-reads them would show it
    start[inst]   = 1'b0;
    rd_mode[inst] = ~rd;
    add_b[inst]   = ~add;
    wr[inst]      = ~wd;
  endtask

  task automatic wait_done(input int inst);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge clk);
      if (done[inst] === 1'b1) seen = 1'b1;
    end
    chk("done_timeout", inst, seen, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    rst_n   = 2'b00;
    start   = 2'b00;
    rd_mode = 2'b00;
    add_b   = '0;
    wr      = '0;
    last_rx = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_sclk", i, sclk[i], 0);
      chk("rst_cs_n", i, cs_n[i], 1);
      chk("rst_mosi", i, mosi[i], 0);
      chk("rst_busy", i, busy[i], 0);
      chk("rst_done", i, done[i], 0);
      chk("rst_rx",   i, rx[i],   0);
    end
    rst_n = 2'b11;
    repeat (2) @(negedge clk);

    // Write 8'b10101101 / 8'h3C, with a stray start at k+50 that must be ignored
    @(negedge clk);
    issue(0, 1'b0, 8'b10101101, 8'h3C, 16'hAD3C, 1, 1, k);
    while (cyc < k + 50) @(negedge clk);
    start[0] = 1'b1; add_b[0] = 8'hFF; wr[0] = 8'hFF; rd_mode[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0);

    // Read address 45: dummy second byte, slave returns A5 on bits 9..16
    @(negedge clk);
    issue(0, 1'b1, 8'd45, 8'h77, 16'h2D00, 1, 1, k);
    wait_done(0);

    // Write: rx_data must hold the previous read byte
    @(negedge clk);
    issue(0, 1'b0, 8'b00000001, 8'h80, 16'h0180, 1, 1, k);
    wait_done(0);

    // Read aborted by reset at k+70 (SCLK high at that point)
    @(negedge clk);
    issue(0, 1'b1, 8'd45, 8'h11, 16'h2D00, 1, 1, k);
    while (cyc < k + 70) @(negedge clk);
    chk("pre_rst_cs_n", 0, cs_n[0], 0);
    chk("pre_rst_sclk", 0, sclk[0], 1);
    rst_n[0] = 1'b0;
    void'(exp_q[0].pop_back());
    last_rx[0] = 8'h00;
    #1;
    chk("abort_cs_n", 0, cs_n[0], 1);
    chk("abort_sclk", 0, sclk[0], 0);
    chk("abort_busy", 0, busy[0], 0);
    chk("abort_rx",   0, rx[0],   0);
    repeat (3) @(negedge clk);
    rst_n[0] = 1'b1;
    repeat (2) @(negedge clk);
    issue(0, 1'b1, 8'd45, 8'h22, 16'h2D00, 1, 1, k);
    wait_done(0);

    // CLK_DIV=1: write, then a read whose start is held through the done
    // cycle (ignored) and the cycle after it (accepted)
    @(negedge clk);
    issue(1, 1'b0, 8'hC3, 8'h5A, 16'hC35A, 1, 1, k);
    wait_done(1);
    issue(1, 1'b1, 8'h81, 8'h99, 16'h8100, 2, 2, k);
    wait_done(1);

    repeat (10) @(negedge clk);
    chk("queue_empty", 0, exp_q[0].size(), 0);
    chk("queue_empty", 1, exp_q[1].size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
